ntt_coeff_loader: RTL and testbench



---
 rtl/ntt_coeff_loader.sv | 134 +++++++++++++
 tb/tb_ntt_coeff_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_coeff_loader.sv
// Packs serial coefficients into INPUT_PER_CYCLE-lane vectors via a two-slot ping-pong buffer.
// Vector valid one cycle after its last lane is accepted; in_ready drops while both slots are full.
module ntt_coeff_loader #(
   parameter int DATA_WIDTH_PER_INPUT = 32,
   parameter int INPUT_PER_CYCLE      = 32,
   parameter int NTT_SIZE             = 1024
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic                            in_start,
   input  logic [DATA_WIDTH_PER_INPUT-1:0] in_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [DATA_WIDTH_PER_INPUT-1:0] out_data [INPUT_PER_CYCLE-1:0],
   output logic                            out_first,
   output logic                            out_last,
   output logic                            err
);
   localparam int VECS   = NTT_SIZE / INPUT_PER_CYCLE;
   localparam int LANE_W = $clog2(INPUT_PER_CYCLE);
   localparam int VEC_W  = (VECS > 1) ? $clog2(VECS) : 1;
   localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(INPUT_PER_CYCLE - 1);
   localparam logic [VEC_W-1:0]  VEC_MAX  = VEC_W'(VECS - 1);

   typedef enum logic {S_IDLE, S_FILL} state_t;

   state_t                          r_state, w_state_nxt;
   logic [LANE_W-1:0]               r_lane_cnt, w_lane_nxt, w_wr_lane;
   logic [VEC_W-1:0]                r_vec_cnt, w_vec_nxt;
   logic                            r_wr_ptr, r_rd_ptr;
   logic [1:0]                      r_count;
   logic [DATA_WIDTH_PER_INPUT-1:0] r_buf [2][INPUT_PER_CYCLE];
   logic                            r_first [2];
   logic                            r_last [2];
   logic                            r_err;
   logic                            w_accept, w_pop, w_wr_en, w_complete, w_set_err;

   assign in_ready  = (r_count < 2'd2);
   assign out_valid = (r_count != 2'd0);
   assign w_accept  = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;
   assign out_first = out_valid & r_first[r_rd_ptr];
   assign out_last  = out_valid & r_last[r_rd_ptr];
   assign err       = r_err;

   always_comb begin
      for (int i = 0; i < INPUT_PER_CYCLE; i++) begin
         out_data[i] = r_buf[r_rd_ptr][i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_lane_nxt  = r_lane_cnt;
      w_vec_nxt   = r_vec_cnt;
      w_wr_lane   = r_lane_cnt;
      w_wr_en     = 1'b0;
      w_complete  = 1'b0;
      w_set_err   = 1'b0;
      if (w_accept) begin
         if (in_start) begin
            // A start always restarts at coefficient 0; any partial vector in the fill slot is overwritten.
            w_wr_en     = 1'b1;
            w_wr_lane   = '0;
            w_lane_nxt  = LANE_W'(1);
            w_vec_nxt   = '0;
            w_state_nxt = S_FILL;
            w_set_err   = (r_state == S_FILL) &&
                          ((r_lane_cnt != '0) || (r_vec_cnt != '0));
         end else if (r_state == S_FILL) begin
            w_wr_en    = 1'b1;
            w_lane_nxt = r_lane_cnt + 1'b1;
            if (r_lane_cnt == LANE_MAX) begin
               w_complete = 1'b1;
               w_vec_nxt  = r_vec_cnt + 1'b1;
               if (r_vec_cnt == VEC_MAX) begin
                  w_vec_nxt   = '0;
                  w_state_nxt = S_IDLE;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lane_cnt <= '0;
         r_vec_cnt  <= '0;
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_count    <= 2'd0;
         r_err      <= 1'b0;
         for (int s = 0; s < 2; s++) begin
            r_first[s] <= 1'b0;
            r_last[s]  <= 1'b0;
            for (int i = 0; i < INPUT_PER_CYCLE; i++) begin
               r_buf[s][i] <= '0;
            end
         end
      end else begin
         r_lane_cnt <= w_lane_nxt;
         r_vec_cnt  <= w_vec_nxt;
         if (w_set_err) begin
            r_err <= 1'b1;
         end
         if (w_wr_en) begin
            r_buf[r_wr_ptr][w_wr_lane] <= in_data;
         end
         if (w_complete) begin
            r_first[r_wr_ptr] <= (r_vec_cnt == '0);
            r_last[r_wr_ptr]  <= (r_vec_cnt == VEC_MAX);
            r_wr_ptr          <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_complete, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: tb/tb_ntt_coeff_loader.sv
// Directed bench for ntt_coeff_loader with NTT_SIZE=64, INPUT_PER_CYCLE=8.
// Popped vectors are captured on the falling edge and compared against hand-derived values.
module tb_ntt_coeff_loader;
   localparam int DW  = 32;
   localparam int IPC = 8;
   localparam int NTT = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          in_start = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data [IPC-1:0];
   logic          out_first;
   logic          out_last;
   logic          err;

   int n_vec = 0;
   int n_err = 0;
   logic            toggle_done;
   logic [IPC*DW-1:0] q_data [$];
   logic            q_first [$];
   logic            q_last [$];

   ntt_coeff_loader #(
      .DATA_WIDTH_PER_INPUT(DW),
      .INPUT_PER_CYCLE(IPC),
      .NTT_SIZE(NTT)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_start(in_start), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_first(out_first), .out_last(out_last), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         logic [IPC*DW-1:0] v;
         for (int i = 0; i < IPC; i++) v[i*DW +: DW] = out_data[i];
         q_data.push_back(v);
         q_first.push_back(out_first);
         q_last.push_back(out_last);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Holds one coefficient on the bus until it is accepted, returning 1 time unit after that edge.
   task automatic send(input logic [DW-1:0] d, input logic s);
      logic got;
      got = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_start = s;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk);
         if (in_ready) got = 1'b1;
      end
      if (!got) check("send_timeout", 0, 1);
      else begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic stream(input int base, input int n);
      for (int i = 0; i < n; i++) send(DW'(base + i), i == 0);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      q_data.delete();
      q_first.delete();
      q_last.delete();
   endtask

   task automatic verify_poly(input int qi, input int base);
      check("poly_qsize_ok", 64'(q_data.size() >= qi + NTT / IPC), 1);
      if (q_data.size() >= qi + NTT / IPC) begin
         for (int k = 0; k < NTT / IPC; k++) begin
            logic [IPC*DW-1:0] v;
            v = q_data[qi + k];
            check("first_tag", q_first[qi + k], k == 0);
            check("last_tag", q_last[qi + k], k == NTT / IPC - 1);
            for (int i = 0; i < IPC; i++) check("lane", v[i*DW +: DW], base + k * IPC + i);
         end
      end
   endtask

   initial begin
      // reset values
      #7;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_first", out_first, 0);
      check("rst_out_last", out_last, 0);
      check("rst_err", err, 0);
      check("rst_data0", out_data[0], 0);
      check("rst_data7", out_data[7], 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // 1: straight stream with consumer always ready
      out_ready = 1'b1;
      for (int i = 0; i < NTT; i++) begin
         send(DW'(i + 1), i == 0);
         if (i == 6) check("lat_before_last_lane", out_valid, 0);
         if (i == 7) check("lat_after_last_lane", out_valid, 1);
      end
      in_valid = 1'b0;
      wait_cycles(10);
      check("t1_nvec", q_data.size(), 8);
      verify_poly(0, 1);
      check("t1_err", err, 0);
      clear_q();

      // 2: consumer stalled, both slots fill, then drain
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) send(DW'(i + 1), i == 0);
      check("t2_in_ready_full", in_ready, 0);
      check("t2_out_valid", out_valid, 1);
      wait_cycles(3);
      check("t2_hold_lane0", out_data[0], 1);
      check("t2_hold_lane7", out_data[7], 8);
      check("t2_hold_first", out_first, 1);
      check("t2_hold_last", out_last, 0);
      out_ready = 1'b1;
      for (int i = 16; i < NTT; i++) send(DW'(i + 1), 1'b0);
      in_valid = 1'b0;
      wait_cycles(10);
      check("t2_nvec", q_data.size(), 8);
      verify_poly(0, 1);
      clear_q();

      // 3: coefficients without a start in IDLE are dropped
      for (int i = 0; i < 5; i++) send(DW'(50 + i), 1'b0);
      stream(100, NTT);
      in_valid = 1'b0;
      wait_cycles(10);
      check("t3_nvec", q_data.size(), 8);
      verify_poly(0, 100);
      check("t3_err", err, 0);
      clear_q();

      // 4: misplaced start after 12 coefficients
      stream(300, 12);
      stream(200, NTT);
      in_valid = 1'b0;
      wait_cycles(10);
      check("t4_nvec", q_data.size(), 9);
      if (q_data.size() >= 1) begin
         logic [IPC*DW-1:0] v;
         v = q_data[0];
         check("t4_old_first", q_first[0], 1);
         check("t4_old_last", q_last[0], 0);
         for (int i = 0; i < IPC; i++) check("t4_old_lane", v[i*DW +: DW], 300 + i);
      end
      verify_poly(1, 200);
      check("t4_err_set", err, 1);
      clear_q();

      // 5: back-to-back polynomials, consumer toggling every cycle
      toggle_done = 1'b0;
      fork
         begin
            stream(400, NTT);
            stream(500, NTT);
            in_valid = 1'b0;
            toggle_done = 1'b1;
         end
         begin
            while (!toggle_done) begin
               @(posedge clk);
               #1;
               out_ready = ~out_ready;
            end
         end
      join
      out_ready = 1'b1;
      wait_cycles(10);
      check("t5_nvec", q_data.size(), 16);
      verify_poly(0, 400);
      verify_poly(8, 500);
      check("t5_err_sticky", err, 1);
      clear_q();

      // 6: asynchronous reset with vectors in flight
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) send(DW'(600 + i), i == 0);
      in_valid = 1'b1;
      in_data  = 616;
      in_start = 1'b0;
      #3;
      rst = 1'b0;
      #1;
      check("t6_rst_in_ready", in_ready, 1);
      check("t6_rst_out_valid", out_valid, 0);
      check("t6_rst_first", out_first, 0);
      check("t6_rst_last", out_last, 0);
      check("t6_rst_err", err, 0);
      check("t6_rst_data0", out_data[0], 0);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      for (int i = 0; i < 2 * IPC; i++) send(DW'(700 + i), 1'b0);
      in_valid = 1'b0;
      wait_cycles(5);
      check("t6_dropped_nvec", q_data.size(), 0);
      check("t6_out_valid", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
